// File: rtl/stage3_pixel_streamer_pkg.sv
// Shared constants, FSM state codes and sizing helper for the stage-3 pixel streamer.
// Fallback values stand in for the shared defines_cnn_core.v when it is not in the compile.
`ifndef ST3_IF_BW
`define ST3_IF_BW 32
`endif
`ifndef POOL_IN_SIZE
`define POOL_IN_SIZE 8
`endif
`ifndef ST3_FRAME_PIX
`define ST3_FRAME_PIX (`POOL_IN_SIZE*`POOL_IN_SIZE)
`endif

package stage3_pixel_streamer_pkg;

    localparam int unsigned ST3_IF_BW_DEF    = `ST3_IF_BW;
    localparam int unsigned POOL_IN_SIZE_DEF = `POOL_IN_SIZE;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_STREAM = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    // Number of pixels in a square feature map of the given side length.
    function automatic int unsigned frame_pix(input int unsigned side);
        return side * side;
    endfunction

endpackage

// File: rtl/stage3_pixel_streamer_if.sv
// Write port, start/stall controls and the outgoing pixel stream of the stage-3 streamer.
interface stage3_pixel_streamer_if
    import stage3_pixel_streamer_pkg::*;
#(
    parameter int unsigned IF_BW = ST3_IF_BW_DEF,
    parameter int unsigned AW    = $clog2(POOL_IN_SIZE_DEF * POOL_IN_SIZE_DEF)
);
    logic             i_wr_en;
    logic [AW-1:0]    i_wr_addr;
    logic [IF_BW-1:0] i_wr_data;
    logic             i_start;
    logic             i_out_stall;
    logic             o_busy;
    logic             o_out_valid;
    logic [IF_BW-1:0] o_out_pixel;
    logic             o_out_first;
    logic             o_out_last;
    logic             o_frame_done;

    modport master (
        output i_wr_en, i_wr_addr, i_wr_data, i_start, i_out_stall,
        input  o_busy, o_out_valid, o_out_pixel, o_out_first, o_out_last, o_frame_done
    );

    modport slave (
        input  i_wr_en, i_wr_addr, i_wr_data, i_start, i_out_stall,
        output o_busy, o_out_valid, o_out_pixel, o_out_first, o_out_last, o_frame_done
    );
endinterface

// File: rtl/stage3_frame_ram.sv
// Simple dual-port frame RAM: one write port, one synchronous read port with a resettable
// output register (the register itself is the streamer's pixel output).
module stage3_frame_ram #(
    parameter int unsigned DW    = 32,
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_en,
    input  logic [AW-1:0] rd_addr,
    output logic [DW-1:0] rd_data
);

    logic [DW-1:0] mem_r [DEPTH];

    // Write port; the storage array is deliberately not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_r[wr_addr] <= wr_data;
        end
    end

    // Synchronous read port, output register holds while no read is issued.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem_r[rd_addr];
        end
    end

endmodule

// File: rtl/stage3_pixel_streamer.sv
// Stage-3 feature-map source: random-access frame fill in IDLE, raster-order
// valid-qualified pixel stream with first/last/done markers.
module stage3_pixel_streamer
    import stage3_pixel_streamer_pkg::*;
#(
    parameter int unsigned IF_BW   = ST3_IF_BW_DEF,
    parameter int unsigned IN_SIZE = POOL_IN_SIZE_DEF,
    parameter int unsigned AW      = $clog2(IN_SIZE * IN_SIZE)
) (
    input  logic                  clk,
    input  logic                  reset_n,
    stage3_pixel_streamer_if.slave bus
);

    localparam int unsigned   FRAME_PIX   = frame_pix(IN_SIZE);
    localparam logic [AW:0]   FRAME_PIX_W = (AW + 1)'(FRAME_PIX);
    localparam logic [AW-1:0] LAST_ADDR   = AW'(FRAME_PIX - 1);

    logic [1:0]       state_r;
    logic [AW-1:0]    rd_cnt_r;
    logic             busy_r;
    logic             valid_r;
    logic             first_r;
    logic             last_r;
    logic             done_r;
    logic             wr_ok_s;
    logic             start_ok_s;
    logic             rd_en_s;
    logic [IF_BW-1:0] rd_data_s;

    // Qualify writes/start to IDLE (frame frozen while streaming) and issue reads when not stalled.
    always_comb begin
        wr_ok_s    = 1'b0;
        start_ok_s = 1'b0;
        rd_en_s    = 1'b0;
        if (state_r == ST_IDLE) begin
            wr_ok_s    = reset_n && bus.i_wr_en && ({1'b0, bus.i_wr_addr} < FRAME_PIX_W);
            start_ok_s = bus.i_start && !busy_r;
        end else if (state_r == ST_STREAM) begin
            rd_en_s = !bus.i_out_stall;
        end else begin
            wr_ok_s    = 1'b0;
            start_ok_s = 1'b0;
            rd_en_s    = 1'b0;
        end
    end

    // FSM, read counter and the stream marker registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_r  <= ST_IDLE;
            rd_cnt_r <= '0;
            busy_r   <= 1'b0;
            valid_r  <= 1'b0;
            first_r  <= 1'b0;
            last_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            valid_r <= 1'b0;
            first_r <= 1'b0;
            last_r  <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    // busy stays high through the done pulse, so a start there is refused
                    busy_r <= start_ok_s;
                    if (start_ok_s) begin
                        state_r  <= ST_STREAM;
                        rd_cnt_r <= '0;
                    end
                end
                ST_STREAM: begin
                    if (rd_en_s) begin
                        valid_r <= 1'b1;
                        first_r <= (rd_cnt_r == '0);
                        last_r  <= (rd_cnt_r == LAST_ADDR);
                        if (rd_cnt_r == LAST_ADDR) begin
                            state_r  <= ST_DONE;
                            rd_cnt_r <= '0;
                        end else begin
                            rd_cnt_r <= rd_cnt_r + 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    done_r  <= 1'b1;
                    state_r <= ST_IDLE;
                end
                default: begin
                    state_r  <= ST_IDLE;
                    rd_cnt_r <= '0;
                    busy_r   <= 1'b0;
                end
            endcase
        end
    end

    stage3_frame_ram #(
        .DW    (IF_BW),
        .DEPTH (FRAME_PIX),
        .AW    (AW)
    ) u_frame_ram (
        .clk     (clk),
        .reset_n (reset_n),
        .wr_en   (wr_ok_s),
        .wr_addr (bus.i_wr_addr),
        .wr_data (bus.i_wr_data),
        .rd_en   (rd_en_s),
        .rd_addr (rd_cnt_r),
        .rd_data (rd_data_s)
    );

    assign bus.o_busy       = busy_r;
    assign bus.o_out_valid  = valid_r;
    assign bus.o_out_pixel  = rd_data_s;
    assign bus.o_out_first  = first_r;
    assign bus.o_out_last   = last_r;
    assign bus.o_frame_done = done_r;

endmodule

// File: tb/tb_stage3_pixel_streamer.sv
// Self-checking bench for stage3_pixel_streamer: reset vector table, directed frames
// and randomized frames against a frame-snapshot scoreboard.
module tb_stage3_pixel_streamer;

    localparam int unsigned IF_BW   = 32;
    localparam int unsigned IN_SIZE = 8;
    localparam int unsigned NPIX    = IN_SIZE * IN_SIZE;
    localparam int unsigned AW      = 6;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    stage3_pixel_streamer_if #(.IF_BW(IF_BW), .AW(AW)) bus ();

    stage3_pixel_streamer #(
        .IF_BW   (IF_BW),
        .IN_SIZE (IN_SIZE),
        .AW      (AW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef struct {
        logic             rst_n;
        logic             start;
        logic             wr_en;
        logic [AW-1:0]    addr;
        logic [IF_BW-1:0] data;
        logic             exp_busy;
    } vec_t;

    vec_t             vecs [6];
    logic [IF_BW-1:0] model_mem [NPIX];
    int               n_checks = 0;
    int               n_fail   = 0;

    task automatic chk(input string name, input logic [IF_BW-1:0] act, input logic [IF_BW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.i_wr_en     = 1'b0;
        bus.i_wr_addr   = '0;
        bus.i_wr_data   = '0;
        bus.i_start     = 1'b0;
        bus.i_out_stall = 1'b0;
    endtask

    task automatic write_px(input int addr, input logic [IF_BW-1:0] data);
        bus.i_wr_en   = 1'b1;
        bus.i_wr_addr = AW'(addr);
        bus.i_wr_data = data;
        step();
        bus.i_wr_en = 1'b0;
        model_mem[addr] = data;
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, 32'(bus.o_out_valid), 32'd0);
        chk({tag, "_done"},  32'(bus.o_frame_done), 32'd0);
        chk({tag, "_busy"},  32'(bus.o_busy), 32'd0);
    endtask

    // One frame: start, then every cycle valid must equal "previous cycle not stalled",
    // valid pixels must be the frame snapshot in raster order, done one cycle after the last.
    task automatic run_frame(input int stall_per, input bit rnd, input bit frozen_wr,
                             input bit start_wr, input bit mid_start);
        int idx = 0;
        int cyc = 0;
        bit st;
        bus.i_start = 1'b1;
        if (start_wr) begin
            bus.i_wr_en   = 1'b1;
            bus.i_wr_addr = '0;
            bus.i_wr_data = 32'h0000_0055;
            model_mem[0]  = 32'h0000_0055;
        end
        step();
        clear_inputs();
        chk("busy_after_start", 32'(bus.o_busy), 32'd1);
        chk("valid_after_start", 32'(bus.o_out_valid), 32'd0);
        while (idx < NPIX && cyc < 2000) begin
            st = rnd ? ($urandom_range(0, 3) == 0) : (stall_per != 0 && (cyc % stall_per) == stall_per - 1);
            bus.i_out_stall = st;
            bus.i_wr_en     = 1'b0;
            bus.i_start     = 1'b0;
            if (frozen_wr && cyc == 5) begin
                bus.i_wr_en   = 1'b1;
                bus.i_wr_addr = 6'd10;
                bus.i_wr_data = 32'h0000_DEAD;
            end else if (rnd && $urandom_range(0, 4) == 0) begin
                bus.i_wr_en   = 1'b1;
                bus.i_wr_addr = AW'($urandom_range(0, NPIX - 1));
                bus.i_wr_data = $urandom;
            end
            if ((mid_start && cyc == 30) || (rnd && $urandom_range(0, 15) == 0)) begin
                bus.i_start = 1'b1;
            end
            step();
            cyc++;
            chk("stream_valid", 32'(bus.o_out_valid), 32'(!st));
            chk("stream_busy", 32'(bus.o_busy), 32'd1);
            chk("stream_done", 32'(bus.o_frame_done), 32'd0);
            if (!st) begin
                chk("pixel", bus.o_out_pixel, model_mem[idx]);
                chk("first", 32'(bus.o_out_first), 32'(idx == 0));
                chk("last",  32'(bus.o_out_last),  32'(idx == NPIX - 1));
                idx++;
            end
        end
        if (cyc >= 2000) begin
            chk("frame_timeout", 32'(idx), 32'(NPIX));
        end
        clear_inputs();
        step();
        chk("done_pulse", 32'(bus.o_frame_done), 32'd1);
        chk("done_no_valid", 32'(bus.o_out_valid), 32'd0);
        chk("done_busy", 32'(bus.o_busy), 32'd1);
        step();
        check_quiet("post_done");
        step();
        check_quiet("idle_after");
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen;
        int cyc;
        reset_n = 1'b0;
        clear_inputs();
        for (int a = 0; a < NPIX; a++) model_mem[a] = '0;

        vecs[0] = '{1'b0, 1'b0, 1'b0, 6'd0,  32'd0,  1'b0};
        vecs[1] = '{1'b0, 1'b0, 1'b0, 6'd0,  32'd0,  1'b0};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 6'd0,  32'd0,  1'b0};
        vecs[3] = '{1'b0, 1'b1, 1'b0, 6'd0,  32'd0,  1'b0};
        vecs[4] = '{1'b1, 1'b0, 1'b1, 6'd0,  32'd1,  1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 6'd63, 32'd64, 1'b0};

        for (int v = 0; v < 6; v++) begin
            reset_n       = vecs[v].rst_n;
            bus.i_start   = vecs[v].start;
            bus.i_wr_en   = vecs[v].wr_en;
            bus.i_wr_addr = vecs[v].addr;
            bus.i_wr_data = vecs[v].data;
            step();
            if (vecs[v].wr_en && vecs[v].rst_n) model_mem[vecs[v].addr] = vecs[v].data;
            chk("vec_busy",  32'(bus.o_busy), 32'(vecs[v].exp_busy));
            chk("vec_valid", 32'(bus.o_out_valid), 32'd0);
            chk("vec_first", 32'(bus.o_out_first), 32'd0);
            chk("vec_last",  32'(bus.o_out_last), 32'd0);
            chk("vec_done",  32'(bus.o_frame_done), 32'd0);
            chk("vec_pixel", bus.o_out_pixel, 32'd0);
        end
        clear_inputs();

        // Basic frame, then the same frame with a stall on every third cycle.
        for (int a = 0; a < NPIX; a++) write_px(a, 32'(a + 1));
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);
        run_frame(3, 1'b0, 1'b0, 1'b0, 1'b0);

        // Write during streaming is dropped; the same write in IDLE lands next frame.
        run_frame(0, 1'b0, 1'b1, 1'b0, 1'b0);
        write_px(10, 32'h0000_DEAD);
        run_frame(2, 1'b0, 1'b0, 1'b0, 1'b0);
        write_px(10, 32'd11);

        // Write together with start, and a start pulse in mid-frame.
        run_frame(0, 1'b0, 1'b0, 1'b1, 1'b1);
        write_px(0, 32'd1);

        // Reset in mid-frame, then restart with preserved contents.
        bus.i_start = 1'b1;
        step();
        bus.i_start = 1'b0;
        seen = 0;
        cyc  = 0;
        while (seen < 20 && cyc < 200) begin
            step();
            cyc++;
            if (bus.o_out_valid) seen++;
        end
        chk("midreset_reach", 32'(seen), 32'd20);
        reset_n = 1'b0;
        step();
        check_quiet("midreset");
        chk("midreset_pixel", bus.o_out_pixel, 32'd0);
        reset_n = 1'b1;
        step();
        check_quiet("after_reset");
        run_frame(0, 1'b0, 1'b0, 1'b0, 1'b0);

        // Randomized frames: random contents, stalls, ignored writes and start pulses.
        for (int f = 0; f < 4; f++) begin
            for (int a = 0; a < NPIX; a++) write_px(a, $urandom);
            run_frame(0, 1'b1, 1'b0, 1'b0, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stage3_pixel_streamer.md
# stage3_pixel_streamer

Stage-3 feature-map source: buffers one `POOL_IN_SIZE` x `POOL_IN_SIZE` feature map written by random-access address, then streams it out in raster order as a `valid`-qualified pixel stream. The output stream feeds the stage-3 pooling line buffer's pixel input, one pixel per cycle. A downstream stall input allows gaps in the stream. Frame boundaries are marked with first, last and done pulses.

## Interface
- `IF_BW`, default `` `ST3_IF_BW ``: pixel width.
- `IN_SIZE`, default `` `POOL_IN_SIZE ``: feature-map side length.
- `AW`, default `$clog2(IN_SIZE*IN_SIZE)`: frame address width.
- `clk`, input, 1: single clock.
- `reset_n`, input, 1: reset, synchronous and active-low.
- `i_wr_en`, input, 1: frame-buffer write strobe.
- `i_wr_addr`, input, AW: raster address, computed as y*IN_SIZE+x.
- `i_wr_data`, input, IF_BW: pixel to store.
- `i_start`, input, 1: single-cycle pulse that begins streaming.
- `i_out_stall`, input, 1: downstream hold. No pixel is issued in a cycle where it is high.
- `o_busy`, output, 1: high from the cycle after `i_start` is accepted until `o_frame_done`, inclusive.
- `o_out_valid`, output, 1: pixel strobe. Connects to the line buffer's input valid.
- `o_out_pixel`, output, IF_BW: streamed pixel.
- `o_out_first`, output, 1: high together with `o_out_valid` for pixel (0,0).
- `o_out_last`, output, 1: high together with `o_out_valid` for pixel (IN_SIZE-1, IN_SIZE-1).
- `o_frame_done`, output, 1: one-cycle pulse after the last pixel.

## Operation
- **FSM states:** IDLE, STREAM, DONE.
- **Reset:** state goes to IDLE and `rd_cnt` to 0. All outputs reset to 0, including `o_out_pixel`. Frame-buffer contents are not reset. A reset in mid-frame abandons the stream, and the next `i_start` restarts from pixel 0.
- **IDLE:**
  - `i_wr_en` writes `i_wr_data` to `mem[i_wr_addr]`. An address of IN_SIZE*IN_SIZE or above is ignored.
  - `i_start` moves the FSM to STREAM with `rd_cnt`=0.
  - A write and `i_start` in the same cycle are both honoured. The written value is the one that gets streamed.
- **STREAM:**
  - In each cycle with `i_out_stall`=0, the block reads `mem[rd_cnt]` and increments `rd_cnt`.
  - In each cycle with `i_out_stall`=1, nothing is read and the count holds.
  - When the read at `rd_cnt`=IN_SIZE*IN_SIZE-1 issues, the FSM moves to DONE.
- **DONE:** lasts one cycle, then returns to IDLE.
- **Ignored inputs:**
  - `i_wr_en` is ignored in STREAM and DONE, so frame contents are frozen while streaming.
  - `i_start` is ignored in STREAM and DONE. It is not queued.
- **Arithmetic:** `rd_cnt` is AW bits wide and never wraps within a frame. `o_out_first` is (`rd_cnt`==0). `o_out_last` is (`rd_cnt`==IN_SIZE*IN_SIZE-1). Both are registered alongside the pixel.
- **Pixel spacing:** consecutive pixels need no gap. The downstream line buffer accepts one pixel per cycle.

## Timing
- `i_start` is sampled at edge N. STREAM holds from N+1, and the first read is issued in cycle N+1.
- Memory read is synchronous, with a 1-cycle output register. Pixel k's `o_out_valid`/`o_out_pixel` appear one cycle after the cycle in which its read issued.
- With no stall, pixel 0 is valid in the cycle after edge N+1 and pixel IN_SIZE²-1 in the cycle after edge N+IN_SIZE².
- `o_out_valid` is low in the cycle after a stalled cycle. Stall-to-valid latency is exactly 1 cycle in both directions.
- `o_frame_done` is asserted one cycle after the last pixel's `o_out_valid`. It never overlaps `o_out_valid`.
- `o_busy` falls in the cycle after `o_frame_done`. A new `i_start` is accepted from that cycle on.

## Structure
- Width and size constants come from the shared `defines_cnn_core.v`, namely `` `ST3_IF_BW `` and `` `POOL_IN_SIZE ``. Add `` `ST3_FRAME_PIX `` (`POOL_IN_SIZE`*`POOL_IN_SIZE`) there.
- One natural sub-module: `stage3_frame_ram`, a simple dual-port RAM with one write port and one synchronous read port of IF_BW x IN_SIZE². It is inferable as BRAM or LUTRAM.
- The FSM, read counter and output registers live in the top module.

## Test plan
- **Reset and idle:** with IN_SIZE=8 and IF_BW=32, hold `reset_n`=0 for 3 cycles -> all outputs 0 and `o_busy`=0. Pulse `i_start` with `reset_n`=0 -> nothing happens.
- **Basic frame:** write `mem[a]`=a+1 for a=0..63, pulse `i_start` with no stall -> exactly 64 consecutive valids with pixels 1..64. `o_out_first` is on pixel 1 and `o_out_last` on pixel 64. `o_frame_done` comes 1 cycle after pixel 64.
- **Stall:** run the basic frame with `i_out_stall` high on every 3rd cycle -> pixels are still 1..64 in order with none lost or duplicated, and each gap follows a stalled cycle by exactly 1 cycle.
- **Frozen frame:** assert `i_wr_en` at addr 10 with data 0xDEAD during STREAM -> pixel 10 still streams as 11. The value 0xDEAD appears only in the following frame if rewritten in IDLE.
- **Simultaneous events:** write addr 0 = 0x55 in the same cycle as `i_start` -> the first pixel is 0x55. Pulse `i_start` again mid-frame -> ignored, giving exactly 64 valids and one done pulse.
- **Reset mid-frame:** deassert `reset_n` after pixel 20 -> `o_out_valid` is low on the next cycle. A fresh `i_start` then streams from pixel 1 with the preserved contents.
